// File: rtl/matrix_pkg.sv
// Shared definitions for the keypad matrix row reader: geometry, key code width,
// FSM state encoding and small index helpers.
package matrix_pkg;

    localparam int NUM_COLS = 5;
    localparam int NUM_ROWS = 4;
    localparam int KEY_W    = 5;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_e;

    // Lowest-index asserted row wins when several rows return at once.
    function automatic logic [1:0] lowest_row(input logic [NUM_ROWS-1:0] rows);
        lowest_row = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (rows[i]) lowest_row = 2'(i);
        end
    endfunction

    function automatic logic [2:0] col_index(input logic [NUM_COLS-1:0] onehot);
        col_index = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (onehot[i]) col_index = 3'(i);
        end
    endfunction

endpackage

// File: rtl/matrix_row_reader_if.sv
// Key event handshake between the row reader (master) and its consumer (slave).
interface matrix_row_reader_if;
    import matrix_pkg::*;

    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_ack;

    modport master (output key_code, output key_valid, input key_ack);
    modport slave  (input key_code, input key_valid, output key_ack);

endinterface

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row returns.
module row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments keep meta and q as two distinct stages.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/matrix_row_reader.sv
// 5x4 keypad scanner with debounce and a valid/ack key event output.
// Optional auto-repeat of a held key is enabled by defining KEY_REPEAT_EN.
module matrix_row_reader
    import matrix_pkg::*;
#(
    parameter int SCAN_DIV     = 8,
    parameter int DEBOUNCE_CNT = 4
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_SCANS = 64
`endif
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NUM_ROWS-1:0] row_i,
    output logic [NUM_COLS-1:0] col_o,
    matrix_row_reader_if.master kif
);

    localparam logic [7:0] DIV_LAST  = 8'(SCAN_DIV - 1);
    localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_CNT);

    state_e              state;
    logic [7:0]          div_cnt;
    logic [3:0]          cnt;
    logic [1:0]          cand_row;
    logic [KEY_W-1:0]    cand_code;
    logic [KEY_W-1:0]    key_code_q;
    logic                key_valid_q;
    logic [NUM_ROWS-1:0] row_s;

    logic                sample_pt;
    logic                cand_high;
    logic                last_match;
    logic [NUM_COLS-1:0] col_next;
    logic [KEY_W-1:0]    scan_code;

    row_sync #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (row_i),
        .q    (row_s)
    );

    assign sample_pt  = (div_cnt == DIV_LAST);
    assign cand_high  = row_s[cand_row];
    assign last_match = ((cnt + 4'd1) >= DB_TARGET);
    assign col_next   = {col_o[NUM_COLS-2:0], col_o[NUM_COLS-1]};
    assign scan_code  = {col_index(col_o), lowest_row(row_s)};

    assign kif.key_code  = key_code_q;
    assign kif.key_valid = key_valid_q;

`ifdef KEY_REPEAT_EN
    localparam int              REP_W    = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
    logic [REP_W-1:0] rep_cnt;
`endif

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state       <= ST_SCAN;
            div_cnt     <= '0;
            cnt         <= '0;
            cand_row    <= '0;
            cand_code   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            col_o       <= NUM_COLS'(1);
`ifdef KEY_REPEAT_EN
            rep_cnt     <= '0;
`endif
        end else begin
            div_cnt <= sample_pt ? '0 : div_cnt + 8'd1;

            // NOTE: the clear comes first so a later set in this block takes precedence.
            if (key_valid_q && kif.key_ack) key_valid_q <= 1'b0;

`ifdef KEY_REPEAT_EN
            if (state != ST_PRESSED || key_valid_q) rep_cnt <= '0;
`endif

            if (sample_pt) begin
                case (state)
                    ST_SCAN: begin
                        if (!key_valid_q && (|row_s)) begin
                            cand_row  <= lowest_row(row_s);
                            cand_code <= scan_code;
                            cnt       <= 4'd1;
                            if (DB_TARGET == 4'd1) begin
                                state       <= ST_PRESSED;
                                key_code_q  <= scan_code;
                                key_valid_q <= 1'b1;
                            end else begin
                                state <= ST_DEBOUNCE;
                            end
                        end else begin
                            col_o <= col_next;
                        end
                    end

                    ST_DEBOUNCE: begin
                        if (!cand_high) begin
                            state <= ST_SCAN;
                            col_o <= col_next;
                        end else if (last_match) begin
                            state       <= ST_PRESSED;
                            key_code_q  <= cand_code;
                            key_valid_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end

                    ST_PRESSED: begin
                        if (!cand_high) begin
                            cnt <= 4'd1;
                            if (DB_TARGET == 4'd1) begin
                                state <= ST_SCAN;
                                col_o <= col_next;
                            end else begin
                                state <= ST_RELEASE;
                            end
                        end
`ifdef KEY_REPEAT_EN
                        else if (!key_valid_q) begin
                            if (rep_cnt == REP_LAST) begin
                                key_valid_q <= 1'b1;
                                rep_cnt     <= '0;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end
`endif
                    end

                    ST_RELEASE: begin
                        if (cand_high) begin
                            state <= ST_PRESSED;
                        end else if (last_match) begin
                            state <= ST_SCAN;
                            col_o <= col_next;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end

                    default: state <= ST_SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_row_reader.sv
// Self-checking bench for matrix_row_reader: a keypad model drives row returns
// from the strobed column, and expected codes/columns come from the key geometry.
module tb_matrix_row_reader;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic        clk;
    logic        rstn;
    logic [3:0]  row_i;
    logic [4:0]  col_o;
    logic [19:0] keys;

    int checks;
    int errors;
    int lat;
    int events;
    int seen;
    int n;
    int c;
    int low;
    int expc;
    logic [3:0] mask;
    logic prev;

    matrix_row_reader_if kif ();

    matrix_row_reader #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
`ifdef KEY_REPEAT_EN
        ,
        .REPEAT_SCANS (8)
`endif
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .row_i (row_i),
        .col_o (col_o),
        .kif   (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key connects its row to its column strobe.
    always_comb begin
        row_i = '0;
        for (int k = 0; k < 5; k++) begin
            if (col_o[k]) row_i = row_i | keys[k*4 +: 4];
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_col_start(input logic [4:0] target);
        int cnt_w;
        cnt_w = 0;
        while (col_o == target && cnt_w < 100) begin tick(); cnt_w++; end
        while (col_o != target && cnt_w < 100) begin tick(); cnt_w++; end
        check("col_start_timeout", int'(cnt_w < 100), 1);
    endtask

    task automatic wait_valid(input int bound, output int latency);
        latency = 0;
        while (!kif.key_valid && latency < bound) begin tick(); latency++; end
        check("valid_timeout", int'(kif.key_valid), 1);
    endtask

    task automatic ack_key();
        kif.key_ack = 1'b1;
        tick();
        kif.key_ack = 1'b0;
        check("ack_clear", int'(kif.key_valid), 0);
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks      = 0;
        errors      = 0;
        rstn        = 1'b1;
        keys        = '0;
        kif.key_ack = 1'b0;
        settle(3);
        check("rst_col", int'(col_o), 1);
        check("rst_valid", int'(kif.key_valid), 0);
        check("rst_code", int'(kif.key_code), 0);

        // Free-running scan: column k is strobed during clocks 4k..4k+3.
        rstn = 1'b0;
        for (int t = 0; t <= 20; t++) begin
            if (t > 0) tick();
            check("scan_col", int'(col_o), 1 << ((t / SCAN_DIV) % 5));
        end
        check("scan_no_valid", int'(kif.key_valid), 0);

        // Key 14 (C3, row 2): confirmed on the third matching sample.
        wait_col_start(5'b01000);
        keys[14] = 1'b1;
        wait_valid(40, lat);
        check("db_latency", lat, DEBOUNCE_CNT * SCAN_DIV);
        check("code_14", int'(kif.key_code), 14);
        check("col_frozen", int'(col_o), 5'b01000);
        ack_key();
        keys = '0;
        settle(40);

        // Single-sample bounce on C1 row 0: no event, scan moves on to C2.
        wait_col_start(5'b00010);
        keys[4] = 1'b1;
        settle(SCAN_DIV);
        keys[4] = 1'b0;
        check("glitch_frozen", int'(col_o), 5'b00010);
        seen = 0;
        repeat (SCAN_DIV) begin
            tick();
            if (kif.key_valid) seen = 1;
        end
        check("glitch_advance", int'(col_o), 5'b00100);
        check("glitch_no_valid", seen, 0);

        // Rows 1 and 3 in C0: lowest row wins. Then a new key waits for the ack.
        wait_col_start(5'b00001);
        keys[1] = 1'b1;
        keys[3] = 1'b1;
        wait_valid(40, lat);
        check("code_1", int'(kif.key_code), 1);
        keys = '0;
        settle(40);
        keys[9] = 1'b1;
        settle(60);
        check("blocked_valid", int'(kif.key_valid), 1);
        check("blocked_code", int'(kif.key_code), 1);
        ack_key();
        wait_valid(60, lat);
        check("code_9", int'(kif.key_code), 9);
        ack_key();
        keys = '0;
        settle(40);

        // Key 14 held for 40 sample points, acknowledged immediately.
        wait_col_start(5'b01000);
        keys[14] = 1'b1;
        events = 0;
        prev   = 1'b0;
        for (int i = 0; i < 40 * SCAN_DIV; i++) begin
            tick();
            if (kif.key_valid && !prev) begin
                events++;
                check("rep_code", int'(kif.key_code), 14);
            end
            prev        = kif.key_valid;
            kif.key_ack = kif.key_valid;
        end
        kif.key_ack = 1'b0;
        keys = '0;
`ifdef KEY_REPEAT_EN
        check("rep_events_in_range", int'(events >= 4 && events <= 6), 1);
`else
        check("one_event", events, 1);
`endif
        settle(40);

        // Reset during debounce.
        wait_col_start(5'b01000);
        keys[14] = 1'b1;
        settle(6);
        rstn = 1'b1;
        #1;
        check("rst_db_col", int'(col_o), 1);
        check("rst_db_valid", int'(kif.key_valid), 0);
        keys = '0;
        settle(2);
        rstn = 1'b0;
        settle(SCAN_DIV - 1);
        check("restart_c0", int'(col_o), 5'b00001);
        tick();
        check("restart_c1", int'(col_o), 5'b00010);

        // Reset with an unacknowledged key pending.
        wait_col_start(5'b01000);
        keys[14] = 1'b1;
        wait_valid(40, lat);
        rstn = 1'b1;
        #1;
        check("rst_pend_valid", int'(kif.key_valid), 0);
        check("rst_pend_code", int'(kif.key_code), 0);
        check("rst_pend_col", int'(col_o), 1);
        keys = '0;
        tick();
        rstn = 1'b0;
        settle(30);
        check("rst_pend_discard", int'(kif.key_valid), 0);

        // Random keys with random extra rows in the same column.
        for (int it = 0; it < 8; it++) begin
            c    = int'($urandom_range(0, 4));
            mask = 4'($urandom_range(1, 15));
            low  = 0;
            for (int r = 3; r >= 0; r--) if (mask[r]) low = r;
            expc = c * 4 + low;
            settle(int'($urandom_range(0, 7)));
            keys[c*4 +: 4] = mask;
            wait_valid(60, lat);
            check("rnd_code", int'(kif.key_code), expc);
            check("rnd_col", int'(col_o), 1 << c);
            repeat (6) begin
                keys[c*4 +: 4] = 4'($urandom) | 4'(1 << low);
                tick();
                check("rnd_hold_code", int'(kif.key_code), expc);
                check("rnd_hold_valid", int'(kif.key_valid), 1);
            end
            ack_key();
            keys = '0;
            n = 0;
            while (int'(col_o) == (1 << c) && n < 80) begin tick(); n++; end
            check("rnd_next_col", int'(col_o), 1 << ((c + 1) % 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
